// File: rtl/spi_master_if.sv
// Host/SPI bundle for spi_master: start/busy/done request handshake plus the
// serial SCLK/SSB/MOSI/MISO lines. "master" is the view taken by spi_master;
// "slave" is the view of whatever drives requests and answers on MISO.
interface spi_master_if #(
  parameter int ADDRSZ  = 7,
  parameter int PAYLOAD = 8
);
  logic               start;
  logic               rw;
  logic [ADDRSZ-1:0]  addr;
  logic [PAYLOAD-1:0] wdata;
  logic               busy;
  logic               done;
  logic [PAYLOAD-1:0] rdata;
  logic               SCLK;
  logic               SSB;
  logic               MOSI;
  logic               MISO;

  modport master (
    input  start, rw, addr, wdata, MISO,
    output busy, done, rdata, SCLK, SSB, MOSI
  );

  modport slave (
    output start, rw, addr, wdata, MISO,
    input  busy, done, rdata, SCLK, SSB, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master issuing one {rw, addr, data} frame per start request.
// SCLK half-period is CLK_DIV clk cycles; frame ends with a 2*CLK_DIV gap
// before done. Optional macro SPI_MASTER_TXN_COUNT_EN adds a frame counter
// (txn_count) with a synchronous clear input (clr_count).
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int ADDRSZ  = 7,
  parameter int PAYLOAD = 8
) (
  input  logic        clk,
  input  logic        reset,
  spi_master_if.master bus
`ifdef SPI_MASTER_TXN_COUNT_EN
  ,
  input  logic        clr_count,
  output logic [15:0] txn_count
`endif
);
  localparam int FW = 1 + ADDRSZ + PAYLOAD;
  localparam int BW = $clog2(FW + 1);
  localparam logic [8:0] PH_LAST  = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

  state_t             state;
  logic [8:0]         cnt;
  logic [FW-1:0]      tx;
  logic [PAYLOAD-1:0] rx;
  logic [BW-1:0]      bits;
  logic               rd_q;
  logic [FW-1:0]      frame;
  logic               ph_end;

  // Read frames carry an all-zero data field.
  assign frame  = {bus.rw, bus.addr, (bus.rw ? {PAYLOAD{1'b0}} : bus.wdata)};
  assign ph_end = (cnt == PH_LAST);

  // Frame sequencer; every bus output is a register written here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tx        <= '0;
      rx        <= '0;
      bits      <= '0;
      rd_q      <= 1'b0;
      bus.SSB   <= 1'b1;
      bus.SCLK  <= 1'b0;
      bus.MOSI  <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            tx       <= frame;
            rd_q     <= bus.rw;
            bits     <= BW'(FW);
            cnt      <= '0;
            bus.SSB  <= 1'b0;
            bus.MOSI <= frame[FW-1];
            bus.busy <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (ph_end) begin
            cnt      <= '0;
            bus.SCLK <= 1'b1;
            state    <= SHIFT_HI;
          end else cnt <= cnt + 9'd1;
        end
        SHIFT_HI: begin
          if (ph_end) begin
            cnt      <= '0;
            rx       <= {rx[PAYLOAD-2:0], bus.MISO};
            bus.SCLK <= 1'b0;
            bits     <= bits - BW'(1);
            tx       <= {tx[FW-2:0], 1'b0};
            if (bits != BW'(1)) begin
              bus.MOSI <= tx[FW-2];
              state    <= SHIFT_LO;
            end else begin
              bus.MOSI <= 1'b0;
              state    <= HOLD;
            end
          end else cnt <= cnt + 9'd1;
        end
        SHIFT_LO: begin
          if (ph_end) begin
            cnt      <= '0;
            bus.SCLK <= 1'b1;
            state    <= SHIFT_HI;
          end else cnt <= cnt + 9'd1;
        end
        HOLD: begin
          if (ph_end) begin
            cnt     <= '0;
            bus.SSB <= 1'b1;
            state   <= GAP;
          end else cnt <= cnt + 9'd1;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            if (rd_q) bus.rdata <= rx;
            state    <= IDLE;
          end else cnt <= cnt + 9'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_TXN_COUNT_EN
  // Completed-frame counter; clear has priority over a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          txn_count <= '0;
    else if (clr_count) txn_count <= '0;
    else if (bus.done)  txn_count <= txn_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: SPI slave model on the serial lines, table vectors,
// random frames against a frame-level reference, and hand-written corner cases.
module tb_spi_master;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_master_if #(.ADDRSZ(7), .PAYLOAD(8)) bus ();

`ifdef SPI_MASTER_TXN_COUNT_EN
  logic        clr_count;
  logic [15:0] txn_count;
  spi_master #(.CLK_DIV(D), .ADDRSZ(7), .PAYLOAD(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .clr_count(clr_count), .txn_count(txn_count));
`else
  spi_master #(.CLK_DIV(D), .ADDRSZ(7), .PAYLOAD(8)) dut (
    .clk(clk), .reset(reset), .bus(bus));
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // monitor state
  int          cyc = 0;
  int          done_cnt = 0, done_cyc = 0;
  int          ssb_fall_cyc = 0, ssb_rise_cyc = 0;
  logic        ssb_prev = 1'b1;
  int          rises = 0, idle_rises = 0;
  logic [15:0] mosi_sh = '0;
  logic [15:0] miso_word = '0;
  int          bitpos = 0;

  // Edge-indexed event log, sampled just after each clk rise.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (ssb_prev && !bus.SSB) ssb_fall_cyc = cyc;
    if (!ssb_prev && bus.SSB) ssb_rise_cyc = cyc;
    if (bus.done) begin done_cnt++; done_cyc = cyc; end
    ssb_prev = bus.SSB;
  end

  // Slave side: capture MOSI on SCLK rise.
  always @(posedge bus.SCLK) begin
    rises++;
    if (bus.SSB) idle_rises++;
    mosi_sh = {mosi_sh[14:0], bus.MOSI};
  end

  // Slave side: present bit k of miso_word (MSB first) from SSB fall / SCLK fall.
  always @(negedge bus.SSB) begin
    bitpos   = 0;
    bus.MISO = miso_word[15];
  end
  always @(negedge bus.SCLK) begin
    if (!bus.SSB) begin
      bitpos++;
      if (bitpos < 16) bus.MISO = miso_word[15 - bitpos];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60 * D; i++) begin
      @(posedge clk); #2;
      if (bus.done) begin got = 1'b1; break; end
    end
  endtask

  // One frame from idle; checks serial image, latency, rise count, rdata.
  task automatic run_frame(input string nm, input logic r, input logic [6:0] a,
                           input logic [7:0] wd, input logic [7:0] mb,
                           input logic [15:0] exp_mosi, input logic [7:0] exp_rd);
    int r0, d0;
    bit got;
    r0 = rises; d0 = done_cnt;
    miso_word = {8'h00, mb};
    bus.start = 1'b1; bus.rw = r; bus.addr = a; bus.wdata = wd;
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.rw = 1'($urandom); bus.addr = 7'($urandom); bus.wdata = 8'($urandom);
    wait_done(got);
    chk({nm, "_done"}, 32'(got), 32'd1);
    chk({nm, "_latency"}, 32'(done_cyc - ssb_fall_cyc), 32'(35 * D));
    chk({nm, "_mosi"}, 32'(mosi_sh), 32'(exp_mosi));
    chk({nm, "_rises"}, 32'(rises - r0), 32'd16);
    chk({nm, "_rdata"}, 32'(bus.rdata), 32'(exp_rd));
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_ndone"}, 32'(done_cnt - d0), 32'd1);
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] miso;
    logic [15:0] exp_mosi;
    logic [7:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [7:0] model_rd;
    bit got;
    int d0, r0, rise1;

    tbl[0] = '{1'b0, 7'h26, 8'hFA, 8'h55, 16'h26FA, 8'h00};
    tbl[1] = '{1'b1, 7'h26, 8'h3C, 8'hFA, 16'hA600, 8'hFA};
    tbl[2] = '{1'b0, 7'h7F, 8'h00, 8'h12, 16'h7F00, 8'hFA};
    tbl[3] = '{1'b1, 7'h00, 8'hFF, 8'h81, 16'h8000, 8'h81};
    tbl[4] = '{1'b0, 7'h4D, 8'hC3, 8'h99, 16'h4DC3, 8'h81};

    reset = 1'b1;
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0; bus.MISO = 1'b0;
`ifdef SPI_MASTER_TXN_COUNT_EN
    clr_count = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ssb",  32'(bus.SSB),  32'd1);
    chk("rst_sclk", 32'(bus.SCLK), 32'd0);
    chk("rst_mosi", 32'(bus.MOSI), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #2;

    // table vectors
    for (int i = 0; i < 5; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].rw, tbl[i].addr, tbl[i].wdata,
                tbl[i].miso, tbl[i].exp_mosi, tbl[i].exp_rdata);
    model_rd = 8'h81;

    // random frames vs frame-level model
    for (int i = 0; i < 12; i++) begin
      logic r; logic [6:0] a; logic [7:0] wd, mb; logic [15:0] em;
      r = 1'($urandom); a = 7'($urandom); wd = 8'($urandom); mb = 8'($urandom);
      em = r ? {1'b1, a, 8'h00} : {1'b0, a, wd};
      if (r) model_rd = mb;
      run_frame($sformatf("rnd%0d", i), r, a, wd, mb, em, model_rd);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2;
    end

    // start while busy is ignored
    d0 = done_cnt; r0 = rises;
    miso_word = 16'h0000;
    bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 7'h15; bus.wdata = 8'hA5;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    bus.start = 1'b1; bus.rw = 1'b1; bus.addr = 7'h7F; bus.wdata = 8'hFF;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (54) @(posedge clk);
    #2;
    bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 7'h00; bus.wdata = 8'h00;
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_done(got);
    chk("ign_done", 32'(got), 32'd1);
    chk("ign_mosi", 32'(mosi_sh), 32'h15A5);
    chk("ign_rises", 32'(rises - r0), 32'd16);
    repeat (4 * D) @(posedge clk);
    #2;
    chk("ign_ndone", 32'(done_cnt - d0), 32'd1);
    chk("ign_ssb", 32'(bus.SSB), 32'd1);

    // back-to-back with start held high
    miso_word = 16'h00C3;
    bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 7'h4D; bus.wdata = 8'hC3;
    @(posedge clk); #2;
    bus.rw = 1'b1; bus.wdata = 8'h11;
    wait_done(got);
    chk("b2b_done1", 32'(got), 32'd1);
    chk("b2b_mosi1", 32'(mosi_sh), 32'h4DC3);
    rise1 = ssb_rise_cyc;
    @(posedge clk); #2;
    bus.start = 1'b0;
    chk("b2b_gap", 32'(ssb_fall_cyc - rise1), 32'(2 * D + 1));
    wait_done(got);
    chk("b2b_done2", 32'(got), 32'd1);
    chk("b2b_mosi2", 32'(mosi_sh), 32'hCD00);
    chk("b2b_rdata", 32'(bus.rdata), 32'hC3);

    // async reset in the middle of a frame
    d0 = done_cnt; r0 = rises;
    miso_word = 16'h0000;
    bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 7'h2A; bus.wdata = 8'h5A;
    @(posedge clk); #2;
    bus.start = 1'b0;
    for (int i = 0; i < 40 * D && rises - r0 < 7; i++) begin
      @(posedge clk); #2;
    end
    @(negedge clk); #1;
    chk("mid_ssb_low", 32'(bus.SSB), 32'd0);
    chk("mid_sclk_hi", 32'(bus.SCLK), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_ssb",  32'(bus.SSB),  32'd1);
    chk("arst_sclk", 32'(bus.SCLK), 32'd0);
    chk("arst_mosi", 32'(bus.MOSI), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_rdata", 32'(bus.rdata), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (40 * D) @(posedge clk);
    #2;
    chk("arst_nodone", 32'(done_cnt - d0), 32'd0);
    run_frame("post_rst", 1'b1, 7'h26, 8'h00, 8'h6B, 16'hA600, 8'h6B);
    chk("idle_rises", 32'(idle_rises), 32'd0);

`ifdef SPI_MASTER_TXN_COUNT_EN
    @(negedge clk) clr_count = 1'b1;
    @(negedge clk) clr_count = 1'b0;
    #1;
    chk("cnt_clr", 32'(txn_count), 32'd0);
    for (int i = 0; i < 3; i++)
      run_frame($sformatf("cnt%0d", i), 1'b0, 7'(i), 8'(i * 3), 8'h00,
                {1'b0, 7'(i), 8'(i * 3)}, 8'h6B);
    repeat (2) @(posedge clk);
    #2;
    chk("cnt_three", 32'(txn_count), 32'd3);
    bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 7'h01; bus.wdata = 8'h02;
    @(posedge clk); #2;
    bus.start = 1'b0;
    for (int i = 0; i < 60 * D && cyc < ssb_fall_cyc + 35 * D - 1; i++) begin
      @(posedge clk); #2;
    end
    clr_count = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    clr_count = 1'b0;
    chk("cnt4_done", 32'(done_cnt > 0 && done_cyc == ssb_fall_cyc + 35 * D), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    chk("cnt_clr_win", 32'(txn_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
